// File: rtl/lpif_rx_pkg.sv
// Shared types and constants for the LPIF downstream receive buffer.
package lpif_rx_pkg;

    localparam int unsigned DROP_CNT_W  = 16;
    localparam int unsigned LPIF_DATA_W = 512;

    // LPIF state codes carried on dstrm_state[3:0]
    localparam logic [3:0] LPIF_ST_RESET     = 4'h0;
    localparam logic [3:0] LPIF_ST_ACTIVE    = 4'h1;
    localparam logic [3:0] LPIF_ST_L1        = 4'h4;
    localparam logic [3:0] LPIF_ST_LINKRESET = 4'h9;
    localparam logic [3:0] LPIF_ST_LINKERROR = 4'hA;
    localparam logic [3:0] LPIF_ST_RETRAIN   = 4'hB;

    typedef enum logic [1:0] {
        StIdle,
        StActive,
        StDrain,
        StError
    } rx_fsm_e;

    // Stored entry layout at the default data width; the top builds the same
    // field order for its configured DATA_W.
    typedef struct packed {
        logic [3:0]             protid;
        logic [1:0]             crc_valid;
        logic [31:0]            crc;
        logic [1:0]             dvalid;
        logic [LPIF_DATA_W-1:0] data;
    } rx_entry_t;

endpackage

// File: rtl/lpif_dstrm_rx_buffer_if.sv
// Downstream flit bus (link -> buffer) and user replay bus (buffer -> consumer).
interface lpif_dstrm_rx_buffer_if #(
    parameter int unsigned DATA_W = 512
);
    logic [7:0]        dstrm_state;
    logic [3:0]        dstrm_protid;
    logic [DATA_W-1:0] dstrm_data;
    logic [1:0]        dstrm_dvalid;
    logic [31:0]       dstrm_crc;
    logic [1:0]        dstrm_crc_valid;
    logic [1:0]        dstrm_valid;

    logic              usr_valid;
    logic              usr_ready;
    logic [DATA_W-1:0] usr_data;
    logic [1:0]        usr_dvalid;
    logic [31:0]       usr_crc;
    logic [1:0]        usr_crc_valid;
    logic [3:0]        usr_protid;

    // Link and consumer side
    modport master (
        output dstrm_state, dstrm_protid, dstrm_data, dstrm_dvalid, dstrm_crc,
               dstrm_crc_valid, dstrm_valid, usr_ready,
        input  usr_valid, usr_data, usr_dvalid, usr_crc, usr_crc_valid, usr_protid
    );

    // Buffer side
    modport slave (
        input  dstrm_state, dstrm_protid, dstrm_data, dstrm_dvalid, dstrm_crc,
               dstrm_crc_valid, dstrm_valid, usr_ready,
        output usr_valid, usr_data, usr_dvalid, usr_crc, usr_crc_valid, usr_protid
    );
endinterface

// File: rtl/lpif_rx_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers. Writes land in storage flops at
// the clock edge; the head entry is read straight off those flops, so a write
// becomes visible the following cycle and never bypasses in the same cycle.
module lpif_rx_sync_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [PTR_W:0]   o_level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;

    // Storage write; contents need no reset since pointers gate visibility
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= i_wdata;
        end
    end

    // Pointer update; flush discards everything without reading it out
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
        end
    end

    assign o_rdata = r_mem[r_rd_ptr[PTR_W-1:0]];
    assign o_level = r_wr_ptr - r_rd_ptr;
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);

endmodule

// File: rtl/lpif_dstrm_rx_buffer.sv
// LPIF downstream receive elastic buffer: captures un-backpressured flits,
// replays them over valid/ready, returns one credit per pop and reports drops.
// Optional build macro: LPIF_DSTRM_PROTID_FILTER_EN adds i_cfg_protid and
// drops flits in ACTIVE whose protid does not match it.
module lpif_dstrm_rx_buffer
    import lpif_rx_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = LPIF_DATA_W,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic                  i_clk_wr,
    input  logic                  i_rst_wr_n,
    input  logic                  i_rx_online,
`ifdef LPIF_DSTRM_PROTID_FILTER_EN
    input  logic [3:0]            i_cfg_protid,
`endif
    input  logic                  i_err_clr,
    lpif_dstrm_rx_buffer_if.slave bus,
    output logic                  o_credit_return,
    output logic [PTR_W:0]        o_fifo_level,
    output logic                  o_overflow_err,
    output logic [DROP_CNT_W-1:0] o_drop_cnt
);

    typedef struct packed {
        logic [3:0]        protid;
        logic [1:0]        crc_valid;
        logic [31:0]       crc;
        logic [1:0]        dvalid;
        logic [DATA_W-1:0] data;
    } entry_t;

    rx_fsm_e               r_state;
    rx_fsm_e               w_state_next;
    logic                  r_credit_return;
    logic                  r_overflow_err;
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    logic   w_link_up, w_push_req, w_protid_ok, w_overflow, w_push, w_pop, w_drop;
    logic   w_accept_st, w_pop_st, w_flush, w_full, w_empty, w_usr_valid;
    logic   w_unused_state;
    entry_t w_wr_entry, w_rd_entry;

    assign w_link_up  = i_rx_online && (bus.dstrm_state[3:0] == LPIF_ST_ACTIVE);
    assign w_push_req = (|bus.dstrm_valid) && (|bus.dstrm_dvalid);
    assign w_unused_state = ^bus.dstrm_state[7:4];

`ifdef LPIF_DSTRM_PROTID_FILTER_EN
    assign w_protid_ok = (bus.dstrm_protid == i_cfg_protid);
`else
    assign w_protid_ok = 1'b1;
`endif

    // Full is the pre-pop value, so a push colliding with a pop on a full FIFO loses
    assign w_overflow = w_accept_st && w_push_req && w_protid_ok && w_full;
    assign w_push     = w_accept_st && w_push_req && w_protid_ok && !w_full;
    assign w_drop     = w_push_req && !w_push;
    assign w_usr_valid = w_pop_st && !w_empty;
    assign w_pop      = w_usr_valid && bus.usr_ready;

    // State register
    always_ff @(posedge i_clk_wr or negedge i_rst_wr_n) begin
        if (!i_rst_wr_n) r_state <= StIdle;
        else             r_state <= w_state_next;
    end

    // Next-state logic; overflow takes priority over link loss
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:   if (w_link_up) w_state_next = StActive;
            StActive: begin
                if (w_overflow)      w_state_next = StError;
                else if (!w_link_up) w_state_next = StDrain;
            end
            StDrain:  if (w_empty)   w_state_next = StIdle;
            StError:  if (i_err_clr) w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    // State-decoded controls
    always_comb begin
        w_accept_st = (r_state == StActive);
        w_pop_st    = (r_state == StActive) || (r_state == StDrain);
        w_flush     = (r_state == StError) && i_err_clr;
    end

    // Pack the incoming flit into a FIFO entry
    always_comb begin
        w_wr_entry.protid    = bus.dstrm_protid;
        w_wr_entry.crc_valid = bus.dstrm_crc_valid;
        w_wr_entry.crc       = bus.dstrm_crc;
        w_wr_entry.dvalid    = bus.dstrm_dvalid;
        w_wr_entry.data      = bus.dstrm_data;
    end

    lpif_rx_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(entry_t))
    ) u_fifo (
        .i_clk   (i_clk_wr),
        .i_rst_n (i_rst_wr_n),
        .i_flush (w_flush),
        .i_push  (w_push),
        .i_wdata (w_wr_entry),
        .i_pop   (w_pop),
        .o_rdata (w_rd_entry),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (o_fifo_level)
    );

    // Sticky overflow flag, saturating drop counter, credit pulse one cycle after pop
    always_ff @(posedge i_clk_wr or negedge i_rst_wr_n) begin
        if (!i_rst_wr_n) begin
            r_credit_return <= 1'b0;
            r_overflow_err  <= 1'b0;
            r_drop_cnt      <= '0;
        end else begin
            r_credit_return <= w_pop;
            if (w_overflow)     r_overflow_err <= 1'b1;
            else if (i_err_clr) r_overflow_err <= 1'b0;
            if (w_drop && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
        end
    end

    // Payload reads as zero whenever nothing is offered
    assign bus.usr_valid     = w_usr_valid;
    assign bus.usr_data      = w_usr_valid ? w_rd_entry.data      : '0;
    assign bus.usr_dvalid    = w_usr_valid ? w_rd_entry.dvalid    : '0;
    assign bus.usr_crc       = w_usr_valid ? w_rd_entry.crc       : '0;
    assign bus.usr_crc_valid = w_usr_valid ? w_rd_entry.crc_valid : '0;
    assign bus.usr_protid    = w_usr_valid ? w_rd_entry.protid    : '0;

    assign o_credit_return = r_credit_return;
    assign o_overflow_err  = r_overflow_err;
    assign o_drop_cnt      = r_drop_cnt;

endmodule

// File: tb/tb_lpif_dstrm_rx_buffer.sv
// Scoreboard bench for lpif_dstrm_rx_buffer (honours LPIF_DSTRM_PROTID_FILTER_EN).
`timescale 1ns/1ps
module tb_lpif_dstrm_rx_buffer;
    import lpif_rx_pkg::*;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned DATA_W = 512;
    localparam int unsigned EW     = DATA_W + 40;
`ifdef LPIF_DSTRM_PROTID_FILTER_EN
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_online = 1'b0;
    logic        err_clr = 1'b0;
`ifdef LPIF_DSTRM_PROTID_FILTER_EN
    logic [3:0]  cfg_protid = 4'h0;
`endif
    logic        credit_return;
    logic        overflow_err;
    logic [4:0]  fifo_level;
    logic [15:0] drop_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int credits  = 0;
    int exp_drop = 0;
    logic [EW-1:0] sb [$];

    lpif_dstrm_rx_buffer_if #(.DATA_W(DATA_W)) bus ();

    lpif_dstrm_rx_buffer #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) dut (
        .i_clk_wr        (clk),
        .i_rst_wr_n      (rst_n),
        .i_rx_online     (rx_online),
`ifdef LPIF_DSTRM_PROTID_FILTER_EN
        .i_cfg_protid    (cfg_protid),
`endif
        .i_err_clr       (err_clr),
        .bus             (bus),
        .o_credit_return (credit_return),
        .o_fifo_level    (fifo_level),
        .o_overflow_err  (overflow_err),
        .o_drop_cnt      (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [EW-1:0] got,
                            input logic [EW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [EW-1:0] usr_entry();
        return {bus.usr_protid, bus.usr_crc_valid, bus.usr_crc, bus.usr_dvalid, bus.usr_data};
    endfunction

    // Pops are observed mid-cycle, where inputs and outputs are stable
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.usr_valid && bus.usr_ready) begin
                if (sb.size() == 0) begin
                    check_eq("pop_extra", {{(EW-1){1'b0}}, bus.usr_valid}, '0);
                end else begin
                    check_eq("pop_data", usr_entry(), sb.pop_front());
                end
            end
            if (credit_return) credits++;
        end
    end

    function automatic logic [EW-1:0] make_entry(input logic [3:0] pid);
        logic [DATA_W-1:0] d;
        for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
        return {pid, 2'($urandom_range(0, 3)), 32'($urandom), 2'($urandom_range(1, 3)), d};
    endfunction

    task automatic drive(input bit vld, input logic [3:0] pid, input bit acc);
        logic [EW-1:0] e;
        @(posedge clk);
        #2;
        e = make_entry(pid);
        {bus.dstrm_protid, bus.dstrm_crc_valid, bus.dstrm_crc, bus.dstrm_dvalid,
         bus.dstrm_data} = e;
        bus.dstrm_valid = vld ? 2'($urandom_range(1, 3)) : 2'b00;
        if (vld) begin
            if (acc) sb.push_back(e);
            else     exp_drop++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 4'h0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        rx_online     = 1'b0;
        err_clr       = 1'b0;
        bus.usr_ready = 1'b0;
        bus.dstrm_valid = 2'b00;
        bus.dstrm_dvalid = 2'b00;
        bus.dstrm_state = 8'h00;
        bus.dstrm_protid = 4'h0;
        bus.dstrm_data = '0;
        bus.dstrm_crc = '0;
        bus.dstrm_crc_valid = '0;
        sb.delete();
        credits  = 0;
        exp_drop = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic go_active(input string tag);
        rx_online = 1'b1;
        bus.dstrm_state = {4'h0, LPIF_ST_ACTIVE};
        idle(2);
        @(negedge clk);
        check_eq(tag, dut.r_state, StActive);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, sb.size(), 0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_valid"}, bus.usr_valid, 0);
        check_eq({tag, "_data"}, usr_entry(), 0);
        check_eq({tag, "_credit"}, credit_return, 0);
        check_eq({tag, "_level"}, fifo_level, 0);
        check_eq({tag, "_ovf"}, overflow_err, 0);
        check_eq({tag, "_drop"}, drop_cnt, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: basic flow, one-cycle latency, credits
        do_reset();
        @(negedge clk);
        check_zero_outputs("t1_reset");
        go_active("t1_active");
        bus.usr_ready = 1'b1;
        drive(1'b1, 4'h1, 1'b1);
        @(negedge clk);
        check_eq("t1_valid_same_cycle", bus.usr_valid, 0);
        drive(1'b1, 4'h1, 1'b1);
        @(negedge clk);
        check_eq("t1_valid_next_cycle", bus.usr_valid, 1);
        drive(1'b1, 4'h1, 1'b1);
        idle(1);
        wait_drain("t1_drain");
        idle(3);
        check_eq("t1_credits", credits, 3);
        check_eq("t1_level", fifo_level, 0);

        // 2: overflow into ERROR, then err_clr flush
        do_reset();
        go_active("t2_active");
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 4'h5, 1'b1);
        drive(1'b1, 4'h5, 1'b0);
        idle(2);
        check_eq("t2_level_full", fifo_level, DEPTH);
        check_eq("t2_ovf", overflow_err, 1);
        check_eq("t2_state_err", dut.r_state, StError);
        check_eq("t2_drop", drop_cnt, exp_drop);
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        @(negedge clk);
        check_eq("t2_level_flushed", fifo_level, 0);
        check_eq("t2_state_idle", dut.r_state, StIdle);
        check_eq("t2_ovf_clr", overflow_err, 0);
        sb.delete();
        idle(3);
        check_eq("t2_no_credits", credits, 0);

        // 3: link drop drains queued entries then refuses pushes
        do_reset();
        go_active("t3_active");
        for (int i = 0; i < 8; i++) drive(1'b1, 4'h7, 1'b1);
        idle(1);
        rx_online = 1'b0;
        bus.usr_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("t3_state_drain", dut.r_state, StDrain);
        wait_drain("t3_drain");
        idle(3);
        check_eq("t3_state_idle", dut.r_state, StIdle);
        check_eq("t3_credits", credits, 8);
        drive(1'b1, 4'h7, 1'b0);
        drive(1'b1, 4'h7, 1'b0);
        idle(2);
        check_eq("t3_drop_idle", drop_cnt, exp_drop);
        check_eq("t3_level", fifo_level, 0);

        // 4: push colliding with pop on a full FIFO
        do_reset();
        go_active("t4_active");
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 4'h9, 1'b1);
        drive(1'b1, 4'h9, 1'b0);
        bus.usr_ready = 1'b1;
        idle(1);
        bus.usr_ready = 1'b0;
        idle(3);
        check_eq("t4_level", fifo_level, DEPTH - 1);
        check_eq("t4_drop", drop_cnt, 1);
        check_eq("t4_credits", credits, 1);
        check_eq("t4_sb_left", sb.size(), DEPTH - 1);

        // 5: protocol-id filter (all accepted when not built in)
        do_reset();
`ifdef LPIF_DSTRM_PROTID_FILTER_EN
        cfg_protid = 4'h2;
`endif
        go_active("t5_active");
        drive(1'b1, 4'h2, 1'b1);
        drive(1'b1, 4'h3, !FILTER);
        drive(1'b1, 4'h2, 1'b1);
        idle(2);
        check_eq("t5_level", fifo_level, FILTER ? 2 : 3);
        check_eq("t5_drop", drop_cnt, exp_drop);
        check_eq("t5_ovf", overflow_err, 0);
        bus.usr_ready = 1'b1;
        wait_drain("t5_drain");
        idle(3);
        check_eq("t5_credits", credits, FILTER ? 2 : 3);

        // 6: asynchronous reset with entries queued
        do_reset();
        drive(1'b1, 4'h4, 1'b0);
        idle(1);
        go_active("t6_active");
        for (int i = 0; i < 5; i++) drive(1'b1, 4'h4, 1'b1);
        idle(2);
        check_eq("t6_level_pre", fifo_level, 5);
        check_eq("t6_drop_pre", drop_cnt, 1);
        #1 rst_n = 1'b0;
        #1;
        check_zero_outputs("t6_reset");
        sb.delete();
        credits = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        bus.usr_ready = 1'b1;
        idle(6);
        check_eq("t6_no_credits", credits, 0);
        check_eq("t6_level_post", fifo_level, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
